// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 responder exposing a 32 x 8 register file
// Command byte selects address/direction; every following data byte hits that same register.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] status_in,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       loc_we,
  input  logic [4:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic       sclk_prev;
  logic       sclk_s, mosi_s, ss_s;
  logic       rise, fall;

  logic [7:0] shift_in, shift_out;
  logic [2:0] bit_cnt;
  logic [4:0] addr;
  logic       dir;
  logic [7:0] rx_byte;
  logic       spi_wr;
  logic [7:0] regs [32];

  // Pure pipelines: they keep tracking the pins through reset so a held-low ss_n is seen at once.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
    sclk_prev <= sclk_s;
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev;
  assign fall    = ~sclk_s & sclk_prev;
  assign rx_byte = {shift_in[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    spi_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s) state_next = CMD;
      end
      CMD, DATA: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (rise && bit_cnt == 3'd7) begin
          if (state == CMD) state_next = DATA;
          else              spi_wr     = dir;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_in  <= '0;
      shift_out <= '0;
      bit_cnt   <= '0;
      addr      <= '0;
      dir       <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= spi_wr;
      if (spi_wr) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
      if (state == IDLE) begin
        if (!ss_s) begin
          shift_out <= status_in;
          bit_cnt   <= '0;
          miso_oe   <= 1'b1;
        end
      end else if (ss_s) begin
        // Deselect abandons any partial byte.
        shift_out <= '0;
        bit_cnt   <= '0;
        miso_oe   <= 1'b0;
      end else if (rise) begin
        shift_in <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (state == CMD && bit_cnt == 3'd7) begin
          addr <= rx_byte[7:3];
          dir  <= rx_byte[1];
        end
      end else if (fall) begin
        // Byte boundary reloads from the register, so a just-written byte echoes back.
        if (bit_cnt == 3'd0) shift_out <= regs[addr];
        else                 shift_out <= {shift_out[6:0], 1'b0};
      end
    end
  end

  // SPI write beats a local write to the same address in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset)                               regs[i] <= '0;
      else if (spi_wr && addr == 5'(i))        regs[i] <= rx_byte;
      else if (loc_we && loc_addr == 5'(i))    regs[i] <= loc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) loc_rdata <= '0;
    else       loc_rdata <= regs[loc_addr];
  end

  assign miso = miso_oe & shift_out[7];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - directed and random SPI/local traffic against a register-array model
// SCLK half period is 8 system clocks; all driving and sampling happens on the falling clk edge.
module tb_spi_reg_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset, sclk, mosi, ss_n, loc_we;
  logic [7:0] status_in, loc_wdata;
  logic [4:0] loc_addr;
  logic       miso, miso_oe, wr_strobe, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data, loc_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model [32];
  logic [7:0]  txd [8];
  logic [12:0] act_q [$];
  logic [12:0] exp_q [$];

  spi_reg_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .status_in(status_in),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) act_q.push_back({wr_addr, wr_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_loc(input logic [4:0] a, input logic [7:0] exp, input string tag);
    loc_addr = a;
    tick(1);
    check($sformatf("%s_loc%0d", tag, a), {24'd0, loc_rdata}, {24'd0, exp});
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    tick(1);
    loc_we = 1'b0;
    model[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) check_loc(5'(i), model[i], tag);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO captured at the rising edge.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit col_en,
                          input logic [4:0] col_addr, input logic [7:0] col_data,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(HALF);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      if (col_en && i == 7) begin
        tick(SYNC);
        loc_we = 1'b1; loc_addr = col_addr; loc_wdata = col_data;
        tick(1);
        loc_we = 1'b0;
        tick(HALF - SYNC - 1);
      end else begin
        tick(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic do_txn(input logic [7:0] cmd, input int nbytes, input int abort_bits,
                        input bit col_en, input logic [4:0] col_addr,
                        input logic [7:0] col_data, input string tag);
    logic [7:0] rx, exp_rx;
    logic [4:0] a;
    logic       w;
    int         n;
    a = cmd[7:3];
    w = cmd[1];
    act_q.delete();
    exp_q.delete();
    ss_n = 1'b0;
    tick(HALF);
    check({tag, "_oe"}, {31'd0, miso_oe}, 32'd1);
    spi_byte(cmd, 8, 1'b0, 5'd0, 8'd0, rx);
    check({tag, "_status"}, {24'd0, rx}, {24'd0, status_in});
    for (int k = 0; k < nbytes; k++) begin
      exp_rx = model[a];
      spi_byte(txd[k], 8, col_en && k == nbytes - 1, col_addr, col_data, rx);
      check($sformatf("%s_miso%0d", tag, k), {24'd0, rx}, {24'd0, exp_rx});
      if (w) begin
        model[a] = txd[k];
        exp_q.push_back({a, txd[k]});
      end
      if (col_en && k == nbytes - 1 && !(w && col_addr == a)) model[col_addr] = col_data;
    end
    if (abort_bits > 0) spi_byte(txd[nbytes], abort_bits, 1'b0, 5'd0, 8'd0, rx);
    tick(HALF);
    ss_n = 1'b1;
    tick(SYNC + 3);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_oe_end"}, {31'd0, miso_oe}, 32'd0);
    check({tag, "_nstrobe"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_strobe%0d", tag, i), {19'd0, act_q[i]}, {19'd0, exp_q[i]});
  endtask

  initial begin
    logic [7:0] rx;
    logic [4:0] ra;
    logic       rw;
    logic [1:0] junk;
    int         nb;

    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0; status_in = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    tick(SYNC + 1);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr", {19'd0, wr_addr, wr_data}, 32'd0);
    check("rst_rdata", {24'd0, loc_rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(2);
    sweep("rst");

    status_in = 8'hA5;
    txd[0] = 8'h5A;
    do_txn(8'h8A, 1, 0, 1'b0, 5'd0, 8'd0, "wr17");
    check_loc(5'd17, 8'h5A, "wr17");

    status_in = 8'h3C;
    txd[0] = 8'h00;
    do_txn(8'h88, 1, 0, 1'b0, 5'd0, 8'd0, "rd17");

    txd[0] = 8'h11; txd[1] = 8'h22; txd[2] = 8'h33;
    do_txn(8'h1A, 3, 0, 1'b0, 5'd0, 8'd0, "multi");
    check_loc(5'd3, 8'h33, "multi");

    txd[0] = 8'hE7;
    do_txn(8'h1A, 0, 5, 1'b0, 5'd0, 8'd0, "abort");
    check_loc(5'd3, 8'h33, "abort");

    txd[0] = 8'h44;
    do_txn(8'h1A, 1, 0, 1'b1, 5'd3, 8'h77, "col_same");
    check_loc(5'd3, 8'h44, "col_same");
    do_txn(8'h1A, 1, 0, 1'b1, 5'd4, 8'h77, "col_diff");
    check_loc(5'd3, 8'h44, "col_diff");
    check_loc(5'd4, 8'h77, "col_diff");

    for (int t = 0; t < 8; t++) begin
      loc_write(5'($urandom_range(0, 31)), 8'($urandom));
      ra = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      junk = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) txd[k] = 8'($urandom);
      status_in = 8'($urandom);
      do_txn({ra, junk[1], rw, junk[0]}, nb, 0, 1'b0, 5'd0, 8'd0, $sformatf("rnd%0d", t));
    end
    sweep("rnd");

    act_q.delete();
    status_in = 8'h96;
    ss_n = 1'b0;
    tick(HALF);
    spi_byte(8'h8A, 8, 1'b0, 5'd0, 8'd0, rx);
    spi_byte(8'hFF, 4, 1'b0, 5'd0, 8'd0, rx);
    mosi = 1'b1;
    tick(HALF);
    sclk = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    ss_n = 1'b1; sclk = 1'b0;
    tick(SYNC + 2);
    reset = 1'b0;
    tick(SYNC + 2);
    check("midrst_nstrobe", act_q.size(), 32'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    sweep("midrst");
    txd[0] = 8'h01;
    do_txn(8'h8A, 1, 0, 1'b0, 5'd0, 8'd0, "after_rst");
    check_loc(5'd17, 8'h01, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
